// File: rtl/fifo_drain_pkg.sv
// fifo_drain_pkg: shared width, FSM state and skid-buffer entry types for fifo_frame_drain.
package fifo_drain_pkg;
    localparam int DATA_WIDTH_DEF = 32;
    typedef enum logic [0:0] {S_DATA, S_CSUM} state_t;
    typedef struct packed {
        logic [DATA_WIDTH_DEF-1:0] data;
        logic                      last;
    } entry_t;
endpackage

// File: rtl/drain_skid_buf.sv
// drain_skid_buf: 2-entry valid/ready output buffer reporting occupancy and FIFO read credit.
module drain_skid_buf
    import fifo_drain_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [DATA_WIDTH_DEF-1:0] push_data,
    input  logic                      push_last,
    input  logic                      inflight,
    input  logic                      ready,
    output logic [DATA_WIDTH_DEF-1:0] head_data,
    output logic                      head_last,
    output logic [1:0]                occ,
    output logic [1:0]                credit
);
    entry_t head, tail, din;
    logic pop;
    assign din = '{data: push_data, last: push_last};
    assign pop = occ != 2'd0 && ready;
    // a pop this cycle frees the slot that a read issued now will land in
    assign credit = 2'd2 - occ - {1'b0, inflight} + {1'b0, pop};
    assign head_data = head.data;
    assign head_last = head.last;
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (pop && occ == 2'd2) head <= tail;
            else if (push && (occ == 2'd0 || (pop && occ == 2'd1))) head <= din;
            if (push && occ == (pop ? 2'd2 : 2'd1)) tail <= din;
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/fifo_frame_drain.sv
// fifo_frame_drain: pops a FIFO into fixed-length frames on a valid/ready/last stream.
// DRAIN_CSUM_EN appends a wrap-around sum word (carrying last) after every frame.
module fifo_frame_drain
    import fifo_drain_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FRAME_LEN  = 4,
    parameter int FCNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    output logic                  fifo_re,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic [FCNT_WIDTH-1:0] frame_cnt
);
    localparam logic [7:0] FL    = 8'(FRAME_LEN);
    localparam logic [7:0] FL_M1 = 8'(FRAME_LEN - 1);

    logic                      rd_pend, push, push_last;
    logic [DATA_WIDTH_DEF-1:0] push_data;
    logic [1:0]                occ, credit;
    logic [7:0]                issued, captured;

    drain_skid_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .push_last (push_last),
        .inflight  (rd_pend),
        .ready     (m_ready),
        .head_data (m_data),
        .head_last (m_last),
        .occ       (occ),
        .credit    (credit)
    );

    assign m_valid = occ != 2'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            rd_pend <= fifo_re;
            if (m_valid && m_ready && m_last) frame_cnt <= frame_cnt + FCNT_WIDTH'(1);
        end
    end

`ifdef DRAIN_CSUM_EN
    state_t                    state;
    logic [DATA_WIDTH_DEF-1:0] sum;
    logic                      csum_push;
    // no read can be in flight in S_CSUM, so the checksum never collides with a capture
    assign csum_push = state == S_CSUM && credit != 2'd0;
    assign fifo_re   = state == S_DATA && !fifo_empty && credit != 2'd0 && issued < FL;
    assign push      = rd_pend || csum_push;
    assign push_data = rd_pend ? fifo_data_out : sum;
    assign push_last = csum_push;
    always_ff @(posedge clk) begin
        if (rst || csum_push) begin
            state    <= S_DATA;
            sum      <= '0;
            issued   <= '0;
            captured <= '0;
        end else begin
            if (fifo_re) issued <= issued + 8'd1;
            if (rd_pend) begin
                sum      <= sum + fifo_data_out;
                captured <= captured + 8'd1;
                if (captured == FL_M1) state <= S_CSUM;
            end
        end
    end
`else
    assign fifo_re   = !fifo_empty && credit != 2'd0 && issued < FL;
    assign push      = rd_pend;
    assign push_data = fifo_data_out;
    assign push_last = captured == FL_M1;
    always_ff @(posedge clk) begin
        if (rst) begin
            issued   <= '0;
            captured <= '0;
        end else begin
            if (fifo_re) issued <= issued + 8'd1;
            if (rd_pend) begin
                issued   <= push_last ? 8'd0 : issued;
                captured <= push_last ? 8'd0 : captured + 8'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_fifo_frame_drain.sv
// tb_fifo_frame_drain: randomized self-checking bench with a queue-based frame/checksum model.
// Checksum expectations follow DRAIN_CSUM_EN when it is defined for the build.
module tb_fifo_frame_drain;
    localparam int FL = 4;
`ifdef DRAIN_CSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1, m_ready = 1'b0;
    logic [31:0] fifo_data_out = '0;
    logic        fifo_empty, fifo_re, m_valid, m_last;
    logic [31:0] m_data;
    logic [15:0] frame_cnt;

    int checks = 0, failures = 0;
    int re_err = 0, hold_err = 0;
    logic [31:0] mem [1024];
    int wr_ptr = 0, rd_ptr = 0;
    logic [31:0] sent[$], got_d[$], exp_d[$];
    bit got_l[$], exp_l[$];
    bit hold_pend = 1'b0;
    logic [31:0] hold_d = '0;
    logic hold_l = 1'b0;

    fifo_frame_drain #(.DATA_WIDTH(32), .FRAME_LEN(FL), .FCNT_WIDTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .fifo_data_out (fifo_data_out),
        .fifo_empty    (fifo_empty),
        .fifo_re       (fifo_re),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_last        (m_last),
        .m_ready       (m_ready),
        .frame_cnt     (frame_cnt)
    );

    always #5 clk = ~clk;

    // FIFO with 1-cycle read latency, cleared by the shared reset
    assign fifo_empty = rd_ptr == wr_ptr;
    always @(posedge clk) begin
        if (rst) rd_ptr <= wr_ptr;
        else if (fifo_re && !fifo_empty) begin
            fifo_data_out <= mem[rd_ptr % 1024];
            rd_ptr <= rd_ptr + 1;
        end
    end

    always @(negedge clk) begin
        if (rst) hold_pend = 1'b0;
        else begin
            if (fifo_re && fifo_empty) re_err++;
            if (hold_pend && (!m_valid || m_data !== hold_d || m_last !== hold_l)) hold_err++;
            if (m_valid && m_ready) begin
                got_d.push_back(m_data);
                got_l.push_back(m_last);
            end
            hold_pend = m_valid && !m_ready;
            hold_d = m_data;
            hold_l = m_last;
        end
    end

    task automatic put(input logic [31:0] w);
        mem[wr_ptr % 1024] = w;
        wr_ptr++;
        sent.push_back(w);
    endtask

    task automatic clear_logs();
        got_d.delete(); got_l.delete(); sent.delete();
        re_err = 0; hold_err = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_logs();
    endtask

    function automatic void build_exp();
        logic [31:0] s = '0;
        int k = 0;
        exp_d.delete(); exp_l.delete();
        foreach (sent[i]) begin
            s += sent[i];
            k++;
            exp_d.push_back(sent[i]);
            exp_l.push_back(!CSUM && k == FL);
            if (k == FL) begin
                if (CSUM) begin
                    exp_d.push_back(s);
                    exp_l.push_back(1'b1);
                end
                s = '0;
                k = 0;
            end
        end
    endfunction

    task automatic wait_drain(input int budget);
        int t = 0;
        build_exp();
        while (got_d.size() < exp_d.size() && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) put($urandom);
        repeat (5) @(posedge clk);
        #1 do_reset();
        checks += 5;
        if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", m_valid); end
        if (m_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b exp=0", m_last); end
        if (m_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", m_data); end
        if (fifo_re !== 1'b0) begin failures++; $display("FAIL reset_re got=%b exp=0", fifo_re); end
        if (frame_cnt !== 16'h0) begin failures++; $display("FAIL reset_fcnt got=%0d exp=0", frame_cnt); end
    endtask

    task automatic test_basic();
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) put(32'(i));
        wait_drain(200);
        checks++;
        if (got_d.size() != exp_d.size()) begin failures++; $display("FAIL basic_count got=%0d exp=%0d", got_d.size(), exp_d.size()); end
        foreach (exp_d[i]) if (i < got_d.size()) begin
            checks++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                failures++; $display("FAIL basic_word[%0d] got=%h/%b exp=%h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
`ifdef DRAIN_CSUM_EN
        checks++;
        if (got_d.size() < 5 || got_d[4] !== 32'd6 || got_l[4] !== 1'b1) begin
            failures++; $display("FAIL basic_csum got_size=%0d exp word4=6 last=1", got_d.size());
        end
`endif
        checks++;
        if (frame_cnt !== 16'd2) begin failures++; $display("FAIL basic_fcnt got=%0d exp=2", frame_cnt); end
    endtask

    task automatic test_backpressure();
        int n = 0;
        do_reset();
        for (int i = 0; i < 8; i++) put($urandom);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (fifo_re) n++;
            if (k >= 3) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== sent[0]) begin
                    failures++; $display("FAIL bp_hold got=%b/%h exp=1/%h", m_valid, m_data, sent[0]);
                end
            end
        end
        checks++;
        if (n > 2) begin failures++; $display("FAIL bp_re_pulses got=%0d exp<=2", n); end
        @(posedge clk);
        #1 m_ready = 1'b1;
        wait_drain(200);
        checks++;
        if (got_d.size() != exp_d.size()) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", got_d.size(), exp_d.size()); end
        foreach (exp_d[i]) if (i < got_d.size()) begin
            checks++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                failures++; $display("FAIL bp_word[%0d] got=%h/%b exp=%h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
        checks++;
        if (hold_err != 0 || re_err != 0) begin failures++; $display("FAIL bp_protocol hold_err=%0d re_err=%0d exp=0/0", hold_err, re_err); end
    endtask

    task automatic test_empty();
        int nre = 0, nvalid = 0;
        do_reset();
        m_ready = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (fifo_re) nre++;
            if (m_valid) nvalid++;
        end
        checks += 2;
        if (nre != 0) begin failures++; $display("FAIL empty_re got=%0d exp=0", nre); end
        if (nvalid != 0) begin failures++; $display("FAIL empty_valid got=%0d exp=0", nvalid); end
        @(posedge clk);
        #1 put($urandom);
        nre = 0;
        repeat (10) begin
            @(negedge clk);
            if (fifo_re) nre++;
        end
        checks++;
        if (nre != 1) begin failures++; $display("FAIL empty_one_pulse got=%0d exp=1", nre); end
        @(posedge clk);
        #1 wait_drain(50);
        checks++;
        if (got_d.size() != 1 || got_d[0] !== sent[0] || got_l[0] !== 1'b0) begin
            failures++; $display("FAIL empty_word got_size=%0d exp_size=1 word=%h", got_d.size(), sent[0]);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        m_ready = 1'b1;
        put(32'hFFFF_FFFF); put(32'h1); put(32'h0); put(32'h0);
        wait_drain(100);
        checks++;
        if (got_d.size() != exp_d.size()) begin failures++; $display("FAIL wrap_count got=%0d exp=%0d", got_d.size(), exp_d.size()); end
        foreach (exp_d[i]) if (i < got_d.size()) begin
            checks++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                failures++; $display("FAIL wrap_word[%0d] got=%h/%b exp=%h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
`ifdef DRAIN_CSUM_EN
        checks++;
        if (got_d.size() < 5 || got_d[4] !== 32'h0 || got_l[4] !== 1'b1) begin
            failures++; $display("FAIL wrap_csum got_size=%0d exp word4=0 last=1", got_d.size());
        end
`endif
    endtask

    task automatic test_reset_mid();
        int t = 0;
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) put($urandom);
        while (got_d.size() < 2 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        clear_logs();
        checks += 2;
        if (m_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", m_valid); end
        if (frame_cnt !== 16'h0) begin failures++; $display("FAIL mid_fcnt got=%0d exp=0", frame_cnt); end
        for (int i = 0; i < 4; i++) put(32'd5);
        wait_drain(100);
        checks++;
        if (got_d.size() != exp_d.size()) begin failures++; $display("FAIL mid_count got=%0d exp=%0d", got_d.size(), exp_d.size()); end
        foreach (exp_d[i]) if (i < got_d.size()) begin
            checks++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                failures++; $display("FAIL mid_word[%0d] got=%h/%b exp=%h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
`ifdef DRAIN_CSUM_EN
        checks++;
        if (got_d.size() < 5 || got_d[4] !== 32'h14) begin failures++; $display("FAIL mid_csum got_size=%0d exp word4=14", got_d.size()); end
`endif
        checks++;
        if (frame_cnt !== 16'd1) begin failures++; $display("FAIL mid_fcnt_after got=%0d exp=1", frame_cnt); end
    endtask

    task automatic test_random();
        int n = 64, idx = 0, t = 0, expn;
        do_reset();
        expn = n + (CSUM ? n / FL : 0);
        while ((idx < n || got_d.size() < expn) && t < 4000) begin
            @(posedge clk);
            #1 m_ready = $urandom_range(0, 3) != 0;
            if (idx < n && $urandom_range(0, 2) != 0) begin
                put($urandom);
                idx++;
            end
            t++;
        end
        m_ready = 1'b1;
        wait_drain(200);
        checks++;
        if (got_d.size() != exp_d.size()) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", got_d.size(), exp_d.size()); end
        foreach (exp_d[i]) if (i < got_d.size()) begin
            checks++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                failures++; $display("FAIL rand_word[%0d] got=%h/%b exp=%h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
        checks += 2;
        if (frame_cnt !== 16'(n / FL)) begin failures++; $display("FAIL rand_fcnt got=%0d exp=%0d", frame_cnt, n / FL); end
        if (hold_err != 0 || re_err != 0) begin failures++; $display("FAIL rand_protocol hold_err=%0d re_err=%0d exp=0/0", hold_err, re_err); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_backpressure();
        test_empty();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_frame_drain.md
Name: fifo_frame_drain

Overview:
- Downstream consumer of the 32-bit synchronous FIFO buffer. It pops words whenever the FIFO is non-empty and it has buffer room.
- Groups popped words into fixed-length frames and appends a 32-bit wrap-around sum checksum word after each frame.
- Presents the stream on a valid/ready master interface with a last flag, for the next stage (packet TX / bus bridge).

Parameters:
- DATA_WIDTH, 32, width of FIFO words and output data.
- FRAME_LEN, 4, data words per frame; legal range 1..255.
- FCNT_WIDTH, 16, width of the completed-frame counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- fifo_data_out  input  DATA_WIDTH  FIFO read data; valid the cycle after fifo_re is sampled high.
- fifo_empty  input  1  FIFO Empty flag.
- fifo_re  output  1  FIFO read enable.
- m_data  output  DATA_WIDTH  output word.
- m_valid  output  1  m_data valid.
- m_last  output  1  marks final word of a frame.
- m_ready  input  1  downstream accept; a transfer occurs when m_valid && m_ready.
- frame_cnt  output  FCNT_WIDTH  completed frames transferred; wraps at 2^FCNT_WIDTH.

Behaviour:
- Reset, synchronous on rst=1 at a clk edge:
  - fifo_re=0, m_valid=0, m_last=0, m_data=0, frame_cnt=0.
  - Skid buffer emptied, running sum=0, word counters=0, state=S_DATA.
  - Reset mid-frame discards the partial frame. Words already popped are lost. The FIFO shares rst and is cleared too.
- FIFO read latency is 1 cycle. A word requested at edge t is captured at edge t+1.
- Skid buffer:
  - 2 entries. Output is taken from the head entry.
  - Credit = 2 − (occupancy + reads in flight). A word is never dropped.
- States:
  - S_DATA:
    - fifo_re = !fifo_empty && credit>0 && issued<FRAME_LEN.
    - Each captured word is pushed to the buffer and added to the running sum (mod 2^32).
    - When FRAME_LEN words have been captured, go to S_CSUM.
  - S_CSUM:
    - fifo_re=0. When credit>0, push the checksum word (the running sum) with last=1.
    - Then clear the sum and issued counters and return to S_DATA.
- Without checksum (see Optional Feature), the last data word carries last=1 and S_CSUM is skipped.
- Output:
  - m_valid = buffer non-empty; m_data and m_last come from the head entry.
  - Hold stable while m_valid && !m_ready.
- Simultaneous push and pop on the same edge is allowed. Occupancy is unchanged.
- Throughput: 1 word/cycle sustained while m_ready=1 and the FIFO is non-empty.
  - Each frame costs one extra cycle for the checksum.
- frame_cnt increments on each transfer with m_last=1.
- fifo_re is never asserted while fifo_empty=1. Full is not observed.

Optional Feature:
- Macro DRAIN_CSUM_EN.
- Defined: checksum word appended; frames are FRAME_LEN+1 words and m_last is on the checksum.
- Undefined: no sum logic, no S_CSUM; frames are FRAME_LEN words and m_last is on data word FRAME_LEN.

Decomposition:
- Package fifo_drain_pkg:
  - DATA_WIDTH_DEF=32.
  - State enum {S_DATA, S_CSUM}.
  - Buffer entry struct {data, last}.
- Sub-module drain_skid_buf: 2-entry valid/ready buffer with push, occupancy and credit outputs.
- FSM, sum and counters live in fifo_frame_drain.

Test Plan:
- DRAIN_CSUM_EN, FRAME_LEN=4, m_ready=1, write 0,1,2,3 → m_data 0,1,2,3,6; m_last only on 6; frame_cnt=1.
- Backpressure: 8 words queued, m_ready=0 for 6 cycles → fifo_re high for ≤2 cycles, then low; m_data holds; after release all words arrive in order, none lost or duplicated.
- Empty FIFO: fifo_empty=1 for 10 cycles → fifo_re=0 and m_valid=0 throughout. One word written → exactly one fifo_re pulse.
- Wrap: words 0xFFFFFFFF,0x1,0x0,0x0 → checksum 0x00000000, m_last=1.
- Reset mid-frame: rst after 2 words transferred → next cycle m_valid=0, frame_cnt=0. New frame 5,5,5,5 → checksum 0x14.
- Macro undefined: write 0..7 → two frames, m_last on 3 and 7, no checksum words, frame_cnt=2.
